div_128: RTL

- Sequential restoring divider: 128-bit dividend by 64-bit divisor, giving a 128-bit quotient and a 64-bit remainder.
- It is the inverse companion of the 64x64 Karatsuba multiplier. In the ElGamal datapath it reduces 128-bit products modulo the 64-bit prime.
- It uses the same valid/ready stream handshake as the multiplier, so the multiplier output feeds it directly.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 29 ++
 rtl/div_128.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: default widths, FSM state
// encoding and the iteration-counter width helper.
package div_pkg;

    localparam int DIVIDEND_W = 128;
    localparam int DIVISOR_W  = 64;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The counter must hold the full iteration count, so it needs one value
    // more than the number of iterations.
    function automatic int cnt_width(input int iters);
        return $clog2(iters + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module div_step #(
    parameter int DIVISOR_W = div_pkg::DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   r_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   r_out,
    output logic                 q_bit
);
    import div_pkg::*;

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;
    logic               unused_r_msb;

    // The incoming remainder is always below the divisor, so its top bit is
    // zero and only the low DIVISOR_W bits take part in the shift.
    assign unused_r_msb = r_in[DIVISOR_W];

    // The shifted value keeps DIVISOR_W+1 bits so the bit pushed out of the
    // top of the remainder still takes part in the compare.
    assign shifted = {r_in[DIVISOR_W-1:0], bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign r_out   = q_bit ? diff : shifted;

endmodule

// File: rtl/div_128.sv
// Sequential restoring divider, 128-bit dividend by 64-bit divisor, with a
// valid/ready stream interface matching the Karatsuba multiplier output.
// BITS_PER_CYCLE quotient bits are resolved per clock (1, 2 or 4).
module div_128 #(
    parameter int DIVIDEND_W     = div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W      = div_pkg::DIVISOR_W,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIVIDEND_W-1:0] input_a_tdata,
    input  logic                  input_a_tvalid,
    output logic                  input_a_tready,
    input  logic [DIVISOR_W-1:0]  input_b_tdata,
    input  logic                  input_b_tvalid,
    output logic                  input_b_tready,
    output logic [DIVIDEND_W-1:0] output_q_tdata,
    output logic [DIVISOR_W-1:0]  output_r_tdata,
    output logic                  output_dbz,
    output logic                  output_tvalid,
    input  logic                  output_tready
);
    import div_pkg::*;

    localparam int ITERS = DIVIDEND_W / BITS_PER_CYCLE;
    localparam int CNT_W = cnt_width(ITERS);

    logic [1:0]                state;
    logic [CNT_W-1:0]          count;
    logic [DIVIDEND_W-1:0]     dvd;          // dividend bits out at the top, quotient bits in at the bottom
    logic [DIVISOR_W-1:0]      dsr;
    logic [DIVISOR_W:0]        rem;
    logic                      dbz_pending;

    logic [DIVISOR_W:0]        r_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [DIVIDEND_W-1:0]     dvd_next;
    logic                      accept;

    // Operands are only ever taken as a pair; a lone valid is never consumed.
    assign accept         = (state == IDLE) & input_a_tvalid & input_b_tvalid;
    assign input_a_tready = (state == IDLE) & input_b_tvalid;
    assign input_b_tready = (state == IDLE) & input_a_tvalid;

    // Chain BITS_PER_CYCLE steps; step k consumes the k-th dividend bit from the top.
    assign r_chain[0] = rem;
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        div_step #(
            .DIVISOR_W (DIVISOR_W)
        ) u_step (
            .r_in    (r_chain[k]),
            .bit_in  (dvd[DIVIDEND_W-1-k]),
            .divisor (dsr),
            .r_out   (r_chain[k+1]),
            .q_bit   (q_bits[BITS_PER_CYCLE-1-k])
        );
    end

    assign dvd_next = {dvd[DIVIDEND_W-BITS_PER_CYCLE-1:0], q_bits};

    // FSM, iteration counter, working registers and output registers.
    // NOTE: every register here is state, so all use non-blocking assignment;
    // reading a register on the same edge always sees its pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            dvd            <= '0;
            dsr            <= '0;
            rem            <= '0;
            dbz_pending    <= 1'b0;
            output_q_tdata <= '0;
            output_r_tdata <= '0;
            output_dbz     <= 1'b0;
            output_tvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd         <= input_a_tdata;
                        dsr         <= input_b_tdata;
                        rem         <= '0;
                        count       <= CNT_W'(ITERS);
                        dbz_pending <= (input_b_tdata == '0);
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (dbz_pending) begin
                        // Divide by zero: report all-ones quotient and the
                        // low dividend word as remainder, skipping iteration.
                        output_q_tdata <= '1;
                        output_r_tdata <= dvd[DIVISOR_W-1:0];
                        output_dbz     <= 1'b1;
                        output_tvalid  <= 1'b1;
                        state          <= DONE;
                    end else begin
                        dvd   <= dvd_next;
                        rem   <= r_chain[BITS_PER_CYCLE];
                        count <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            output_q_tdata <= dvd_next;
                            output_r_tdata <= r_chain[BITS_PER_CYCLE][DIVISOR_W-1:0];
                            output_dbz     <= 1'b0;
                            output_tvalid  <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (output_tready) begin
                        output_tvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
